dot_operand_loader: RTL
=======================

// Module: dot_operand_loader
// PURPOSE
// - Upstream feeder for the dot-product MAC engine (controlpath + datapath).
// - Accepts a length command and N (a,b) operand pairs from a host over valid/ready, buffers them all.
// - Only then pulses go; streams one pair per cycle while the engine asserts ld_a.
// - Holds off new work until the engine reports eoc.
// PARAMETERS
// - DW     16  width of each operand a, b
// - DEPTH  16  max vector length N buffered (power of 2)
// - NW     5   width of length field; must hold DEPTH (clog2(DEPTH)+1)
// PORTS
// - clk        in   1   single clock, rising edge
// - rst_n      in   1   asynchronous active-low reset
// - cmd_valid  in   1   host presents vector length
// - cmd_ready  out  1   high only in IDLE
// - cmd_len    in   NW  vector length N
// - in_valid   in   1   host presents an operand pair
// - in_ready   out  1   high only in FILL
// - in_a       in   DW  operand a
// - in_b       in   DW  operand b
// - go         out  1   one-cycle start pulse to engine
// - n_out      out  NW  length to engine N counter; held stable from LAUNCH until IDLE
// - a_out      out  DW  operand to engine A register, valid in the same cycle as ld_a
// - b_out      out  DW  operand to engine B register, valid in the same cycle as ld_a
// - ld_a       in   1   engine load strobe; one pair consumed per cycle high
// - eoc        in   1   engine end-of-computation, level
// - busy       out  1   high in any state except IDLE
// - err_len    out  1   one-cycle pulse: command rejected
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; wr_ptr=rd_ptr=cnt=0; n_out=0.
//   - go=0, err_len=0, a_out=b_out=0; cmd_ready=1, in_ready=0, busy=0.
// - States: IDLE, FILL, LAUNCH, STREAM, DRAIN.
//   - IDLE: cmd_valid&cmd_ready -> latch n_out=cmd_len, clear ptrs, go FILL.
//     - If cmd_len==0 or cmd_len>DEPTH: pulse err_len next cycle, stay IDLE, n_out unchanged.
//   - FILL: each in_valid&in_ready writes (in_a,in_b) at wr_ptr, wr_ptr++.
//     - After the N-th write, in_ready drops and the next state is LAUNCH.
//   - LAUNCH: go=1 for exactly this cycle -> STREAM.
//   - STREAM: each cycle ld_a=1, rd_ptr++ and a_out/b_out advance combinationally from buffer[rd_ptr].
//     - Once rd_ptr==N, a_out=b_out=0, so any surplus load adds 0 to acc.
//     - eoc=1 -> DRAIN.
//   - DRAIN: wait for eoc=0 or one cycle, whichever first, then IDLE.
//     - The engine has no restart, so only reset re-arms it; DRAIN protects the loader.
// - Latency: last accepted pair -> go is exactly 2 cycles (FILL exit, LAUNCH).
// - Handshake: transfer only when valid&ready on the same edge.
//   - Host data may change freely while ready=0.
//   - cmd_valid is ignored outside IDLE.
// - ld_a outside STREAM is ignored, with no pointer motion.
// - eoc before rd_ptr reaches N is legal: go DRAIN; unread pairs are discarded.
// - Pointers: log2(DEPTH) bits plus an explicit count; no wrap within one vector.
// - Buffer contents are not reset; only pointers are.
// - Reset mid-operation: immediate return to IDLE; partial vector is discarded; go never glitches high.
// STRUCTURE
// - Shared package dot_pkg:
//   - loader state encoding (3-bit localparams)
//   - DW/NW defaults shared with the datapath
// - One sub-module dot_operand_buf: DEPTH x 2*DW register file.
//   - 1 synchronous write port, 1 asynchronous read port, no reset.
// - Top holds the FSM, pointers, handshakes and output muxing.
// TESTING
// - Reset then cmd_len=3, pairs (2,3),(4,5),(6,7) -> go pulses 2 cycles after the 3rd pair, n_out=3.
//   - With ld_a high 3 cycles: a_out/b_out = 2/3, 4/5, 6/7; with a 4th ld_a cycle: 0/0.
// - cmd_len=0, then cmd_len=DEPTH+1 -> err_len pulses each time; state stays IDLE; go never asserts.
// - Host in_valid gapped (1 on, 2 off), N=DEPTH -> all 16 pairs stored in order, in_ready=0 after the 16th.
// - eoc asserted after 2 of 4 loads -> DRAIN, then IDLE; cmd_ready=1; the next command's pairs read from index 0.
// - rst_n low mid-FILL (after 2 of 5 pairs) -> outputs at reset values within the same cycle.
//   - A new N=1 command then completes normally.
// - ld_a pulsed in IDLE/FILL -> no pointer change; later stream output starts at pair 0.

Source files
------------

// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - shared widths and loader state encoding for the dot-product engine
package dot_pkg;

  localparam int DOT_DW    = 16;
  localparam int DOT_DEPTH = 16;
  localparam int DOT_NW    = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_LAUNCH = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4
  } loader_state_e;

endpackage

// File: rtl/dot_operand_loader_if.sv
// rtl/dot_operand_loader_if.sv - host and engine signals of the operand loader
interface dot_operand_loader_if
  import dot_pkg::*;
#(
  parameter int DW = DOT_DW,
  parameter int NW = DOT_NW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [NW-1:0] cmd_len;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          go;
  logic [NW-1:0] n_out;
  logic [DW-1:0] a_out;
  logic [DW-1:0] b_out;
  logic          ld_a;
  logic          eoc;
  logic          busy;
  logic          err_len;

  // master drives commands, operands and the engine strobes
  modport master (
    output cmd_valid, cmd_len, in_valid, in_a, in_b, ld_a, eoc,
    input  cmd_ready, in_ready, go, n_out, a_out, b_out, busy, err_len
  );

  modport slave (
    input  cmd_valid, cmd_len, in_valid, in_a, in_b, ld_a, eoc,
    output cmd_ready, in_ready, go, n_out, a_out, b_out, busy, err_len
  );

endinterface

// File: rtl/dot_operand_buf.sv
// rtl/dot_operand_buf.sv - operand pair register file, sync write, async read, no reset
module dot_operand_buf #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dot_operand_loader.sv
// rtl/dot_operand_loader.sv - buffers a whole operand vector, then streams it to the MAC engine
module dot_operand_loader
  import dot_pkg::*;
#(
  parameter int DW    = DOT_DW,
  parameter int DEPTH = DOT_DEPTH,
  parameter int NW    = DOT_NW
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  dot_operand_loader_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  loader_state_e r_state;
  loader_state_e w_next;

  logic [NW-1:0]   r_n;
  logic [NW-1:0]   r_cnt;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic            r_go;
  logic            r_err_len;
  logic            w_len_bad;
  logic            w_cmd_fire;
  logic            w_wr_en;
  logic            w_rd_ok;
  logic            w_rd_en;
  logic [2*DW-1:0] w_rdata;

  assign w_len_bad  = (bus.cmd_len == '0) || (bus.cmd_len > NW'(DEPTH));
  assign w_cmd_fire = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_wr_en    = (r_state == S_FILL) && bus.in_valid && (r_cnt != r_n);
  // r_cnt counts writes during FILL and is reused as the read count once LAUNCH clears it
  assign w_rd_ok    = (r_state == S_STREAM) && (r_cnt != r_n);
  assign w_rd_en    = w_rd_ok && bus.ld_a;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_cmd_fire && !w_len_bad) w_next = S_FILL;
      S_FILL:   if (r_cnt == r_n) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_STREAM;
      S_STREAM: if (bus.eoc) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_cnt     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_go      <= 1'b0;
      r_err_len <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_go      <= (w_next == S_LAUNCH);
      r_err_len <= w_cmd_fire && w_len_bad;
      if (w_cmd_fire && !w_len_bad) begin
        r_n      <= bus.cmd_len;
        r_cnt    <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_cnt    <= r_cnt + NW'(1);
      end
      if (r_state == S_LAUNCH) r_cnt <= '0;
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_cnt    <= r_cnt + NW'(1);
      end
    end
  end

  dot_operand_buf #(
    .W  (2*DW),
    .AW (AW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata ({bus.in_a, bus.in_b}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.in_ready  = (r_state == S_FILL) && (r_cnt != r_n);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.go        = r_go;
  assign bus.err_len   = r_err_len;
  assign bus.n_out     = r_n;
  // past the end of the vector the engine sees zeros so surplus loads add nothing
  assign bus.a_out     = w_rd_ok ? w_rdata[2*DW-1:DW] : '0;
  assign bus.b_out     = w_rd_ok ? w_rdata[DW-1:0]    : '0;

endmodule
